// File: rtl/mcu0_intc.sv
// mcu0_intc: edge-triggered priority interrupt controller feeding the mcu0 core's interrupt/irq inputs.
// Optional round-robin priority with `define MCU0_INTC_ROTATE_EN (fixed priority, index 0 highest, otherwise).
module mcu0_intc #(
  parameter int unsigned NSRC  = 8,
  parameter int unsigned VEC_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NSRC-1:0]  src,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [15:0]      cfg_wdata,
  output logic [15:0]      cfg_rdata,
  output logic             interrupt,
  output logic [VEC_W-1:0] irq,
  input  logic             ack,
  input  logic             eoi
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_t;

  state_t           r_state;
  logic [NSRC-1:0]  r_src_d;
  logic [NSRC-1:0]  r_pend;
  logic [NSRC-1:0]  r_mask;
  logic [VEC_W-1:0] r_irq;
  logic             r_int;
`ifdef MCU0_INTC_ROTATE_EN
  logic [VEC_W-1:0] r_last;
`endif

  logic [NSRC-1:0]  w_rise;
  logic [NSRC-1:0]  w_elig;
  logic [NSRC-1:0]  w_clr;
  logic [NSRC-1:0]  w_pend_nxt;
  logic [VEC_W-1:0] w_winner;
  logic             w_found;
  logic             w_wr_mask;
  logic             w_wr_pend;
  logic             w_ack_req;
  logic             w_unused_wdata;

  assign w_rise         = src & ~r_src_d;
  assign w_elig         = r_pend & r_mask;
  assign w_wr_mask      = cfg_we && (cfg_addr == 2'd0);
  assign w_wr_pend      = cfg_we && (cfg_addr == 2'd1);
  assign w_ack_req      = (r_state == ST_REQ) && ack;
  assign w_unused_wdata = ^cfg_wdata;

  // Set beats clear: a fresh edge survives a simultaneous W1C or ack clear.
  assign w_clr = (w_wr_pend ? cfg_wdata[NSRC-1:0] : '0)
               | (w_ack_req ? (NSRC'(1) << r_irq) : '0);
  assign w_pend_nxt = (r_pend & ~w_clr) | w_rise;

  // Rotating search: first pass covers indices above last grant, second pass wraps from 0.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
`ifdef MCU0_INTC_ROTATE_EN
    for (int unsigned j = 0; j < NSRC; j++) begin
      if (!w_found && w_elig[j] && (j > 32'(r_last))) begin
        w_winner = VEC_W'(j);
        w_found  = 1'b1;
      end
    end
`endif
    for (int unsigned j = 0; j < NSRC; j++) begin
      if (!w_found && w_elig[j]) begin
        w_winner = VEC_W'(j);
        w_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_src_d <= '1;
      r_pend  <= '0;
      r_mask  <= '0;
      r_irq   <= '0;
      r_int   <= 1'b0;
`ifdef MCU0_INTC_ROTATE_EN
      r_last  <= VEC_W'(NSRC - 1);
`endif
    end else begin
      r_src_d <= src;
      r_pend  <= w_pend_nxt;
      if (w_wr_mask) begin
        r_mask <= cfg_wdata[NSRC-1:0];
      end
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_irq   <= w_winner;
            r_int   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack) begin
            r_int   <= 1'b0;
            r_state <= ST_SVC;
`ifdef MCU0_INTC_ROTATE_EN
            r_last  <= r_irq;
`endif
          end
        end
        ST_SVC: begin
          if (eoi) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_int   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0: cfg_rdata[NSRC-1:0] = r_mask;
      2'd1: cfg_rdata[NSRC-1:0] = r_pend;
      2'd2: begin
        cfg_rdata[15:14] = r_state;
        cfg_rdata[2:0]   = r_irq;
`ifdef MCU0_INTC_ROTATE_EN
        cfg_rdata[6:4]   = r_last;
`endif
      end
      default: cfg_rdata = '0;
    endcase
  end

  assign interrupt = r_int;
  assign irq       = r_irq;

endmodule

// File: tb/tb_mcu0_intc.sv
// Directed self-checking bench for mcu0_intc; expectations follow the build's MCU0_INTC_ROTATE_EN setting.
module tb_mcu0_intc;

`ifdef MCU0_INTC_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  src;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;
  logic        interrupt;
  logic [2:0]  irq;
  logic        ack;
  logic        eoi;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clock = ~clock;

  mcu0_intc #(
    .NSRC (8),
    .VEC_W(3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .src      (src),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .interrupt(interrupt),
    .irq      (irq),
    .ack      (ack),
    .eoi      (eoi)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [15:0] exp);
    cfg_addr = addr;
    #1;
    check(tag, cfg_rdata, exp);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [15:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] v);
    src = v;
    tick();
    src = '0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  // Expected STATUS word: state, irq, and last grant only when rotation is built in.
  function automatic logic [15:0] st(input logic [1:0] s, input logic [2:0] q, input logic [2:0] last);
    logic [15:0] v;
    v = {s, 11'b0, q};
    if (ROT) v[6:4] = last;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] first;
    logic [2:0] second;
    logic [2:0] rr_exp [4];

    reset = 1'b1; src = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; ack = 1'b0; eoi = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_int", interrupt, 16'd0);
    check("rst_irq", irq, 16'd0);
    rd_chk("rst_mask", 2'd0, 16'h0000);
    rd_chk("rst_pend", 2'd1, 16'h0000);
    rd_chk("rst_stat", 2'd2, st(2'd0, 3'd0, 3'd7));
    rd_chk("rst_addr3", 2'd3, 16'h0000);

    // single source, latency and service
    wr(2'd0, 16'h00FF);
    rd_chk("t1_mask", 2'd0, 16'h00FF);
    pulse(8'h20);
    rd_chk("t1_pend", 2'd1, 16'h0020);
    check("t1_int_early", interrupt, 16'd0);
    tick();
    check("t1_int", interrupt, 16'd1);
    check("t1_irq", irq, 16'd5);
    rd_chk("t1_stat_req", 2'd2, st(2'd1, 3'd5, 3'd7));
    do_ack();
    check("t1_int_ack", interrupt, 16'd0);
    rd_chk("t1_pend_ack", 2'd1, 16'h0000);
    rd_chk("t1_stat_svc", 2'd2, st(2'd2, 3'd5, 3'd5));
    do_eoi();
    rd_chk("t1_stat_idle", 2'd2, st(2'd0, 3'd5, 3'd5));

    // two simultaneous sources
    first  = ROT ? 3'd6 : 3'd2;
    second = ROT ? 3'd2 : 3'd6;
    pulse(8'h44);
    tick();
    check("t2_int1", interrupt, 16'd1);
    check("t2_irq1", irq, 16'(first));
    do_ack();
    rd_chk("t2_pend_left", 2'd1, ROT ? 16'h0004 : 16'h0040);
    do_eoi();
    check("t2_idle_gap", interrupt, 16'd0);
    rd_chk("t2_stat_gap", 2'd2, st(2'd0, first, first));
    tick();
    check("t2_int2", interrupt, 16'd1);
    check("t2_irq2", irq, 16'(second));
    do_ack();
    do_eoi();
    rd_chk("t2_pend_done", 2'd1, 16'h0000);

    // masked source, late unmask, W1C while committed
    wr(2'd0, 16'h0000);
    pulse(8'h08);
    tick(); tick();
    check("t3_masked_int", interrupt, 16'd0);
    rd_chk("t3_pend", 2'd1, 16'h0008);
    wr(2'd0, 16'h0008);
    tick();
    check("t3_int", interrupt, 16'd1);
    check("t3_irq", irq, 16'd3);
    wr(2'd1, 16'h0008);
    check("t3_w1c_int", interrupt, 16'd1);
    rd_chk("t3_w1c_pend", 2'd1, 16'h0000);
    wr(2'd0, 16'h0000);
    tick();
    check("t3_hold_int", interrupt, 16'd1);
    check("t3_hold_irq", irq, 16'd3);
    do_ack();
    check("t3_ack_int", interrupt, 16'd0);
    rd_chk("t3_stat_svc", 2'd2, st(2'd2, 3'd3, 3'd3));
    do_eoi();

    // no nesting; ack+eoi together; stray ack
    wr(2'd0, 16'h00FF);
    pulse(8'h02);
    tick();
    check("t4_irq1", irq, 16'd1);
    ack = 1'b1; eoi = 1'b1;
    tick();
    ack = 1'b0; eoi = 1'b0;
    rd_chk("t4_ackeoi_stat", 2'd2, st(2'd2, 3'd1, 3'd1));
    pulse(8'h01);
    tick(); tick();
    check("t4_svc_int", interrupt, 16'd0);
    rd_chk("t4_svc_pend", 2'd1, 16'h0001);
    do_eoi();
    check("t4_gap_int", interrupt, 16'd0);
    tick();
    check("t4_int0", interrupt, 16'd1);
    check("t4_irq0", irq, 16'd0);
    do_ack();
    do_eoi();
    do_ack();
    check("t4_stray_ack_int", interrupt, 16'd0);
    rd_chk("t4_stray_ack_stat", 2'd2, st(2'd0, 3'd0, 3'd0));

    // line high across reset, then reset mid-request
    reset = 1'b1; src = 8'h10;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    rd_chk("t5_no_spur", 2'd1, 16'h0000);
    src = '0;
    tick();
    src = 8'h10;
    tick();
    rd_chk("t5_pend", 2'd1, 16'h0010);
    src = '0;
    wr(2'd0, 16'h0010);
    tick();
    check("t5_req_int", interrupt, 16'd1);
    rd_chk("t5_req_stat", 2'd2, st(2'd1, 3'd4, 3'd7));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_int", interrupt, 16'd0);
    rd_chk("t5_rst_pend", 2'd1, 16'h0000);
    rd_chk("t5_rst_stat", 2'd2, st(2'd0, 3'd0, 3'd7));

    // repeated pair: fixed priority keeps granting 1, rotation alternates
    rr_exp[0] = 3'd1;
    rr_exp[1] = ROT ? 3'd2 : 3'd1;
    rr_exp[2] = 3'd1;
    rr_exp[3] = ROT ? 3'd2 : 3'd1;
    wr(2'd0, 16'h0006);
    pulse(8'h06);
    tick();
    check("t6_int_0", interrupt, 16'd1);
    check("t6_irq_0", irq, 16'(rr_exp[0]));
    do_ack();
    for (int unsigned r = 1; r < 4; r++) begin
      pulse(8'h06);
      do_eoi();
      tick();
      check($sformatf("t6_int_%0d", r), interrupt, 16'd1);
      check($sformatf("t6_irq_%0d", r), irq, 16'(rr_exp[r]));
      do_ack();
    end
    do_eoi();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
